// File: rtl/decade_counter_slowena_pkg.sv
// Shared defaults for the decimal digit counters.
// Sibling digit counters in a display chain reuse these defaults.
package decade_counter_slowena_pkg;

    localparam int unsigned DIGIT_WIDTH   = 4;
    localparam int unsigned DIGIT_MODULUS = 10;

endpackage : decade_counter_slowena_pkg

// File: rtl/decade_counter_slowena.sv
// Single BCD digit, 0..MODULUS-1, that advances only on edges where slowena is high.
// Any carry into a following digit is generated by the parent, not by this module.
module decade_counter_slowena
    import decade_counter_slowena_pkg::*;
#(
    parameter int unsigned WIDTH   = DIGIT_WIDTH,
    parameter int unsigned MODULUS = DIGIT_MODULUS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slowena,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    // Next count. The >= compare sends unreachable codes back to 0.
    always_comb begin
        w_q_next = r_q;
        if (slowena) begin
            if (r_q >= TERMINAL) begin
                w_q_next = '0;
            end else begin
                w_q_next = r_q + WIDTH'(1);
            end
        end else begin
            w_q_next = r_q;
        end
    end

    // Count register. Reset takes priority over the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

endmodule : decade_counter_slowena

// File: tb/tb_decade_counter_slowena.sv
// Scoreboard bench for decade_counter_slowena: stimulus pushes expected counts,
// and a monitor pops and compares them after every rising edge.
module tb_decade_counter_slowena;

    logic       clk;
    logic       reset;
    logic       slowena;
    logic [3:0] q;

    typedef struct {
        int    exp;
        string name;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   bad;
    int   m_q;
    bit   m_valid;

    decade_counter_slowena #(.WIDTH(4), .MODULUS(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .slowena (slowena),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the registered count is presented after every rising edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            total++;
            if (q !== 4'(e.exp)) begin
                bad++;
                $display("FAIL %s: q=%0d expected=%0d at %0t", e.name, q, e.exp, $time);
            end
        end
    end

    // One cycle: drive inputs at the falling edge, confirm q has not moved
    // between edges, then queue the value expected after the next rising edge.
    task automatic step(input logic rst, input logic en, input string name);
        exp_t e;
        @(negedge clk);
        reset   = rst;
        slowena = en;
        #1;
        if (m_valid) begin
            total++;
            if (q !== 4'(m_q)) begin
                bad++;
                $display("FAIL %s_midcycle: q=%0d expected=%0d at %0t", name, q, m_q, $time);
            end
        end
        if (rst)          m_q = 0;
        else if (en)      m_q = (m_q >= 9) ? 0 : m_q + 1;
        m_valid = m_valid || rst;
        e.exp  = m_q;
        e.name = name;
        if (m_valid) sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, pending=%0d", sb_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        total   = 0;
        bad     = 0;
        m_q     = 0;
        m_valid = 1'b0;
        reset   = 1'b0;
        slowena = 1'b0;

        // Reset with enable high, release, then count 1..9,0,1.
        step(1'b1, 1'b1, "reset_0");
        step(1'b1, 1'b1, "reset_1");
        step(1'b0, 1'b0, "post_reset_hold");
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, "count_up");

        // Synchronous reset raised at a count of 3.
        step(1'b1, 1'b0, "pre_reset");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "count_to_3");
        step(1'b1, 1'b1, "sync_reset_at_3");
        step(1'b1, 1'b1, "reset_held_0");
        step(1'b1, 1'b0, "reset_held_1");

        // Hold at terminal count, then wrap on the enabled edge.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, "count_to_9");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "hold_at_9");
        step(1'b0, 1'b1, "wrap_9_to_0");

        // Enable gating with random slowena.
        step(1'b1, 1'b0, "gate_reset");
        for (int i = 0; i < 15; i++) step(1'b0, 1'($urandom_range(0, 1)), "enable_gating");

        // Reset wins over enable at a count of 7.
        step(1'b1, 1'b0, "prio_reset");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "count_to_7");
        step(1'b1, 1'b1, "reset_priority_at_7");

        // Random soak: 200 cycles, checked at both edges.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 25), "soak");
        end

        @(negedge clk);
        reset   = 1'b0;
        slowena = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_decade_counter_slowena
